// File: rtl/shift_i2c_mem_path.sv
// shift_i2c_mem_path: universal shift register feeding a bit-serial
// I2C-style link whose slave end writes a 16x8 memory.
//
// Ports:
//   clk, rst (async, active-low)
//   data_in[7:0], S[2:0], MSBIn, LSBIn, enable : shift register control
//   master_addr[7:0]                           : target address of a frame
//   Q[7:0]          : shift register contents
//   masterdata[7:0] : data byte latched at frame start
//   dataout[7:0]    : last byte written to memory
//   done, nack      : one-cycle frame completion pulse / address rejected
module shift_i2c_mem_path #(
    parameter int MEM_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic [2:0] S,
    input  logic       MSBIn,
    input  logic       LSBIn,
    input  logic       enable,
    input  logic [7:0] master_addr,
    output logic [7:0] Q,
    output logic [7:0] masterdata,
    output logic [7:0] dataout,
    output logic       done,
    output logic       nack
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ACK1, DATA, ACK2, STOP
    } state_t;

    state_t state, nxt;

    logic [2:0]    cnt;
    logic [7:0]    m_sh;
    logic [7:0]    s_sh;
    logic [AW-1:0] s_addr;
    logic [AW-1:0] last_addr;
    logic          s_ack;
    logic          scl_q;
    logic          scl;
    logic          sda;
    logic          addr_ok;
    logic          shifting;
    logic          stop_det;
    logic [7:0]    mem [MEM_DEPTH];

    assign addr_ok  = s_sh < 8'(MEM_DEPTH);
    assign shifting = (state == ADDR) || (state == DATA);
    // Stop condition: sda high while scl high during STOP.
    assign stop_det = (state == STOP) && scl && sda;
    // Memory is never written before reset, so the word at the last
    // written address is exactly the last byte written.
    assign dataout  = mem[last_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q <= 8'h00;
        end else if (enable) begin
            unique case (S)
                3'b000: Q <= Q;
                3'b001: Q <= data_in;
                3'b010: Q <= {MSBIn, Q[7:1]};
                3'b011: Q <= {Q[6:0], LSBIn};
                3'b100: Q <= {Q[0], Q[7:1]};
                3'b101: Q <= {Q[6:0], Q[7]};
                3'b110: Q <= 8'h00;
                3'b111: Q <= ~Q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = enable ? START : IDLE;
            START:   nxt = ADDR;
            ADDR:    nxt = (cnt == 3'd7) ? ACK1 : ADDR;
            // Master samples the slave's ACK bit; NACK skips DATA.
            ACK1:    nxt = sda ? STOP : DATA;
            DATA:    nxt = (cnt == 3'd7) ? ACK2 : DATA;
            ACK2:    nxt = STOP;
            STOP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        sda = 1'b1;
        scl = scl_q;
        unique case (state)
            IDLE:    begin sda = 1'b1;     scl = 1'b1; end
            START:   sda = 1'b0;
            ADDR:    sda = m_sh[7];
            ACK1:    sda = ~addr_ok;
            DATA:    sda = m_sh[7];
            ACK2:    sda = 1'b0;
            STOP:    begin sda = 1'b1;     scl = 1'b1; end
            default: begin sda = 1'b1;     scl = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 3'd0;
            m_sh       <= 8'h00;
            s_sh       <= 8'h00;
            s_addr     <= '0;
            last_addr  <= '0;
            s_ack      <= 1'b0;
            scl_q      <= 1'b0;
            masterdata <= 8'h00;
            done       <= 1'b0;
            nack       <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            scl_q <= (state == IDLE) ? 1'b0 : ~scl_q;
            cnt   <= shifting ? cnt + 3'd1 : 3'd0;
            done  <= stop_det;
            nack  <= stop_det && !s_ack;
            if (state == START) begin
                m_sh       <= master_addr;
                masterdata <= Q;
            end
            if (shifting) begin
                m_sh <= {m_sh[6:0], 1'b0};
                s_sh <= {s_sh[6:0], sda};
            end
            if (state == ACK1) begin
                m_sh   <= masterdata;
                s_addr <= s_sh[AW-1:0];
                s_ack  <= addr_ok;
            end
            if (stop_det && s_ack) begin
                mem[s_addr] <= s_sh;
                last_addr   <= s_addr;
            end
        end
    end

endmodule

// File: tb/tb_shift_i2c_mem_path.sv
// Directed bench for shift_i2c_mem_path: shift modes, frame write,
// NACK path, short window and mid-frame reset.
module tb_shift_i2c_mem_path;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic [2:0] S;
    logic       MSBIn;
    logic       LSBIn;
    logic       enable;
    logic [7:0] master_addr;
    logic [7:0] Q;
    logic [7:0] masterdata;
    logic [7:0] dataout;
    logic       done;
    logic       nack;

    int passed = 0;
    int total  = 0;

    shift_i2c_mem_path dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .S           (S),
        .MSBIn       (MSBIn),
        .LSBIn       (LSBIn),
        .enable      (enable),
        .master_addr (master_addr),
        .Q           (Q),
        .masterdata  (masterdata),
        .dataout     (dataout),
        .done        (done),
        .nack        (nack)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        enable = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        data_in     = 8'h00;
        S           = 3'b000;
        MSBIn       = 1'b0;
        LSBIn       = 1'b0;
        enable      = 1'b0;
        master_addr = 8'h00;
        #1;
        chk("rst_q",    Q,             8'h00);
        chk("rst_dout", dataout,       8'h00);
        chk("rst_mdat", masterdata,    8'h00);
        chk("rst_done", {7'b0, done},  8'h00);
        chk("rst_nack", {7'b0, nack},  8'h00);
        tick(2);
        rst = 1'b1;

        data_in = 8'h40; S = 3'b001; enable = 1'b1;
        tick(1);
        chk("load", Q, 8'h40);
        enable = 1'b0; data_in = 8'hFF;
        tick(2);
        chk("hold_en0", Q, 8'h40);
        enable = 1'b1; S = 3'b010; MSBIn = 1'b1;
        tick(1);
        chk("shr", Q, 8'hA0);
        S = 3'b001; data_in = 8'h40;
        tick(1);
        S = 3'b011; LSBIn = 1'b1;
        tick(1);
        chk("shl", Q, 8'h81);
        S = 3'b100;
        tick(1);
        chk("rotr", Q, 8'hC0);
        S = 3'b101;
        tick(1);
        chk("rotl", Q, 8'h81);
        S = 3'b111;
        tick(1);
        chk("invert", Q, 8'h7E);
        S = 3'b000;
        tick(1);
        chk("hold_s0", Q, 8'h7E);
        S = 3'b110;
        tick(1);
        chk("clear", Q, 8'h00);

        do_reset();
        chk("rst2_q", Q, 8'h00);
        S = 3'b001; data_in = 8'h40; enable = 1'b1; master_addr = 8'h05;
        tick(1);
        chk("f1_e1_q",    Q,            8'h40);
        chk("f1_e1_done", {7'b0, done}, 8'h00);
        tick(1);
        chk("f1_e2_mdat", masterdata,   8'h40);
        enable = 1'b0; data_in = 8'h00;
        tick(18);
        chk("f1_e20_done", {7'b0, done}, 8'h00);
        chk("f1_e20_dout", dataout,      8'h00);
        tick(1);
        chk("f1_e21_done", {7'b0, done}, 8'h01);
        chk("f1_e21_nack", {7'b0, nack}, 8'h00);
        chk("f1_e21_dout", dataout,      8'h40);
        tick(1);
        chk("f1_e22_done", {7'b0, done}, 8'h00);
        chk("f1_e22_dout", dataout,      8'h40);

        data_in = 8'hC3; enable = 1'b1; master_addr = 8'h0F;
        tick(1);
        enable = 1'b0;
        tick(1);
        chk("f2_mdat", masterdata, 8'hC3);
        tick(18);
        chk("f2_e20_done", {7'b0, done}, 8'h00);
        tick(1);
        chk("f2_e21_done", {7'b0, done}, 8'h01);
        chk("f2_e21_nack", {7'b0, nack}, 8'h00);
        chk("f2_e21_dout", dataout,      8'hC3);
        tick(1);

        data_in = 8'h99; enable = 1'b1; master_addr = 8'h10;
        tick(1);
        enable = 1'b0;
        tick(10);
        chk("nk_e11_done", {7'b0, done}, 8'h00);
        tick(1);
        chk("nk_e12_done", {7'b0, done}, 8'h01);
        chk("nk_e12_nack", {7'b0, nack}, 8'h01);
        chk("nk_e12_dout", dataout,      8'hC3);
        tick(1);
        chk("nk_e13_done", {7'b0, done}, 8'h00);
        chk("nk_e13_nack", {7'b0, nack}, 8'h00);
        tick(12);
        chk("nk_late_dout", dataout,      8'hC3);
        chk("nk_late_done", {7'b0, done}, 8'h00);

        do_reset();
        data_in = 8'h5A; S = 3'b001; enable = 1'b1; master_addr = 8'h05;
        tick(3);
        chk("short_dout", dataout,      8'h00);
        chk("short_done", {7'b0, done}, 8'h00);
        chk("short_mdat", masterdata,   8'h5A);
        enable = 1'b0;
        tick(7);
        rst = 1'b0;
        #1;
        chk("mid_q",    Q,            8'h00);
        chk("mid_mdat", masterdata,   8'h00);
        chk("mid_dout", dataout,      8'h00);
        chk("mid_done", {7'b0, done}, 8'h00);
        chk("mid_nack", {7'b0, nack}, 8'h00);
        tick(1);
        rst = 1'b1;
        tick(25);
        chk("mid_nowrite_dout", dataout,      8'h00);
        chk("mid_nowrite_done", {7'b0, done}, 8'h00);

        data_in = 8'h3C; enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(1);
        chk("re_mdat", masterdata, 8'h3C);
        tick(18);
        chk("re_e20_done", {7'b0, done}, 8'h00);
        tick(1);
        chk("re_e21_done", {7'b0, done}, 8'h01);
        chk("re_e21_dout", dataout,      8'h3C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
